// File: rtl/window_reader.sv
`default_nettype none
// ============================================================================
// window_reader : snapshots the circular sample window, streams it oldest-first
// Revision      : 1.0
// ============================================================================
module window_reader #(
  parameter int SAMPLES_SIZE = 64,
  parameter int WIDTH        = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    start_in,
  input  logic signed [WIDTH-1:0] sample_in [SAMPLES_SIZE],
  input  logic [((SAMPLES_SIZE > 1) ? $clog2(SAMPLES_SIZE) : 1)-1:0] offset_in,
  output logic signed [WIDTH-1:0] sample_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    last_out,
  output logic                    busy_out,
  output logic                    done_out
);

  localparam int IW = (SAMPLES_SIZE > 1) ? $clog2(SAMPLES_SIZE) : 1;
  localparam logic [IW-1:0] c_LAST_IDX = IW'(SAMPLES_SIZE - 1);
  localparam logic          c_SINGLE   = (SAMPLES_SIZE == 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic signed [WIDTH-1:0] r_snap [SAMPLES_SIZE];
  logic [IW-1:0]           r_base, w_base_nxt;
  logic [IW-1:0]           r_idx, w_idx_nxt;
  logic signed [WIDTH-1:0] r_sample, w_sample_nxt;
  logic                    r_valid, w_valid_nxt;
  logic                    r_last, w_last_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;
  logic                    w_capture;
  logic                    w_hs;
  logic [IW-1:0]           w_idx_inc;
  logic [IW-1:0]           w_addr;

  assign w_hs      = r_valid & ready_in;
  assign w_idx_inc = r_idx + IW'(1);
  // Natural IW-bit wrap walks the ring from the oldest entry.
  assign w_addr    = r_base + w_idx_inc;

  always_comb begin
    w_state_nxt  = r_state;
    w_base_nxt   = r_base;
    w_idx_nxt    = r_idx;
    w_sample_nxt = r_sample;
    w_valid_nxt  = r_valid;
    w_last_nxt   = r_last;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_capture    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        if (start_in) begin
          // First sample bypasses the snapshot so it is valid next cycle.
          w_capture    = 1'b1;
          w_base_nxt   = offset_in;
          w_idx_nxt    = '0;
          w_sample_nxt = sample_in[offset_in];
          w_valid_nxt  = 1'b1;
          w_busy_nxt   = 1'b1;
          w_last_nxt   = c_SINGLE;
          w_state_nxt  = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_hs) begin
          if (r_idx == c_LAST_IDX) begin
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt    = w_idx_inc;
            w_sample_nxt = r_snap[w_addr];
            w_last_nxt   = (w_idx_inc == c_LAST_IDX);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_idx    <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_base   <= w_base_nxt;
      r_idx    <= w_idx_nxt;
      r_sample <= w_sample_nxt;
      r_valid  <= w_valid_nxt;
      r_last   <= w_last_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Snapshot storage carries no reset; it is always rewritten before use.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && w_capture) begin
      for (int i = 0; i < SAMPLES_SIZE; i++) begin
        r_snap[i] <= sample_in[i];
      end
    end
  end

  assign sample_out = r_sample;
  assign valid_out  = r_valid;
  assign last_out   = r_last;
  assign busy_out   = r_busy;
  assign done_out   = r_done;

endmodule
`default_nettype wire
